// File: rtl/fpu_norm_pkg.sv
// fpu_norm_pkg: shared widths and pipeline record types for the FPU normalization arbiter
package fpu_norm_pkg;
  localparam int MANT_W = 32;
  localparam int LZC_W = 5;
  localparam int EXP_W = 10;
  localparam int N_REQ = 2;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MANT_W-1:0] mant;
  } norm_req_t;
  typedef struct packed {
    norm_req_t req;
    logic [LZC_W-1:0] c;
    logic v;
    logic id;
  } norm_s1_t;
endpackage

// File: rtl/fpu_rr_arb.sv
// fpu_rr_arb: 2-way round-robin grant; the pointer moves past the winner only on a handshake
module fpu_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       id
);
  logic ptr;
  always_comb begin
    id = ptr ? req[1] : !req[0];
    gnt = en ? ({id, !id} & req) : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (|gnt) ptr <= !id;
endmodule

// File: rtl/lzc_32.sv
// lzc_32: leading-zero count of a 32-bit word; zero flags an all-zero input
module lzc_32 (
  input  logic [31:0] a,
  output logic [4:0]  cnt,
  output logic        zero
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) if (a[i]) cnt = 5'(31 - i);
    zero = a == '0;
  end
endmodule

// File: rtl/fpu_norm_arbiter.sv
// fpu_norm_arbiter: round-robin shared LZC/shift/exponent-adjust normalizer, 2-stage valid/ready pipeline.
// Define FPU_NORM_SUBNORM_EN for gradual underflow; default flushes underflow to zero.
module fpu_norm_arbiter #(
  parameter int N_REQ  = 2,
  parameter int EXP_W  = 10,
  parameter int MANT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*MANT_W-1:0] req_mant,
  input  logic [N_REQ*EXP_W-1:0]  req_exp,
  input  logic [N_REQ-1:0]        req_sign,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_id,
  output logic [MANT_W-1:0]       out_mant,
  output logic [EXP_W-1:0]        out_exp,
  output logic                    out_sign,
  output logic                    out_zero,
  output logic                    out_uf,
  output logic                    busy
);
  import fpu_norm_pkg::*;
  if (MANT_W != 32 || N_REQ != 2 || EXP_W != fpu_norm_pkg::EXP_W) begin : g_bad_cfg
    $error("fpu_norm_arbiter: MANT_W must be 32, N_REQ 2, EXP_W must match fpu_norm_pkg");
  end
  logic [1:0] gnt;
  logic gid, s1_en, s1_valid, s2_ready, v, uf;
  logic [LZC_W-1:0] c;
  logic [EXP_W:0] e;
  logic [MANT_W-1:0] n_mant;
  norm_req_t sel;
  norm_s1_t s1;
  assign s2_ready = !out_valid || out_ready;
  // reset also closes the input handshake so nothing is accepted while held
  assign s1_en = rst_n && (!s1_valid || s2_ready);
  assign req_ready = gnt;
  assign busy = s1_valid || out_valid;
  assign sel = {req_sign[gid], req_exp[int'(gid)*EXP_W +: EXP_W], req_mant[int'(gid)*MANT_W +: MANT_W]};
  fpu_rr_arb u_arb (.clk(clk), .rst_n(rst_n), .en(s1_en), .req(req_valid), .gnt(gnt), .id(gid));
  lzc_32 u_lzc (.a(sel.mant), .cnt(c), .zero(v));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1 <= '0;
    end else if (s1_en) begin
      s1_valid <= |gnt;
      if (|gnt) s1 <= {sel, c, v, gid};
    end
`ifdef FPU_NORM_SUBNORM_EN
  logic [EXP_W:0] em1;
  logic [LZC_W-1:0] sh;
  always_comb begin
    e = {s1.req.exp[EXP_W-1], s1.req.exp} - (EXP_W+1)'(s1.c);
    uf = e[EXP_W] || e == '0;
    em1 = {s1.req.exp[EXP_W-1], s1.req.exp} - (EXP_W+1)'(1);
    sh = (em1[EXP_W] || em1 == '0) ? '0 : (em1 < (EXP_W+1)'(s1.c)) ? em1[LZC_W-1:0] : s1.c;
    n_mant = s1.v ? '0 : s1.req.mant << (uf ? sh : s1.c);
  end
`else
  always_comb begin
    e = {s1.req.exp[EXP_W-1], s1.req.exp} - (EXP_W+1)'(s1.c);
    uf = e[EXP_W] || e == '0;
    n_mant = (s1.v || uf) ? '0 : s1.req.mant << s1.c;
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id <= 1'b0;
      out_mant <= '0;
      out_exp <= '0;
      out_sign <= 1'b0;
      out_zero <= 1'b0;
      out_uf <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_id <= s1.id;
        out_mant <= n_mant;
        out_exp <= (s1.v || uf) ? '0 : e[EXP_W-1:0];
        out_sign <= s1.req.sign;
        out_zero <= s1.v;
        out_uf <= !s1.v && uf;
      end
    end
endmodule

// File: tb/tb_fpu_norm_arbiter.sv
// tb_fpu_norm_arbiter: directed vector table plus handwritten stream/backpressure/reset sequences
module tb_fpu_norm_arbiter;
  localparam int EW = 10;
  localparam int MW = 32;
`ifdef FPU_NORM_SUBNORM_EN
  localparam bit SN = 1'b1;
`else
  localparam bit SN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req_valid, req_ready, req_sign;
  logic [2*MW-1:0] req_mant;
  logic [2*EW-1:0] req_exp;
  logic out_valid, out_ready, out_id, out_sign, out_zero, out_uf, busy;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  int checks = 0, failures = 0;
  fpu_norm_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mant(req_mant), .req_exp(req_exp), .req_sign(req_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_zero(out_zero), .out_uf(out_uf), .busy(busy)
  );
  typedef struct {
    logic id; logic sign; logic [31:0] mant; logic [9:0] exp;
    logic [31:0] e_mant; logic [9:0] e_exp; logic e_zero; logic e_uf;
  } vec_t;
  typedef struct { logic id; logic [31:0] mant; } sb_t;
  vec_t vt[9];
  sb_t q[$];
  int seq[2];
  int hs_cnt, push_cnt, pop_cnt;
  logic [1:0] last_ready;
  logic [63:0] snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic s, input logic [9:0] e, input logic [31:0] m);
    req_sign[i] = s;
    req_exp[i*EW +: EW] = e;
    req_mant[i*MW +: MW] = m;
  endtask

  task automatic stream(input int n, input logic [1:0] v, input logic ordy);
    logic [31:0] m[2];
    sb_t x;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        m[i] = 32'h8000_0000 | 32'(i << 8) | 32'(seq[i] & 255);
        set_req(i, 1'(i), 10'd100, m[i]);
      end
      req_valid = v;
      out_ready = ordy;
      #1;
      last_ready = req_ready;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_extra", 64'(out_valid), 64'd0);
        else begin
          x = q.pop_front();
          chk("sb_data", {out_id, out_mant, out_exp}, {x.id, x.mant, 10'd100});
        end
        pop_cnt++;
      end
      for (int i = 0; i < 2; i++)
        if (req_ready[i]) begin
          q.push_back('{1'(i), m[i]});
          seq[i]++;
          hs_cnt++;
          push_cnt++;
        end
      tick();
    end
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h0000_1000, 10'd100, 32'h8000_0000, 10'd81, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 32'h0000_0000, 10'd50, 32'h0, 10'd0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 32'h0000_0001, 10'd10, SN ? 32'h0000_0200 : 32'h0, 10'd0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 32'h8000_0000, 10'd1, 32'h8000_0000, 10'd1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b0, 32'h0000_FFFF, 10'd17, 32'hFFFF_0000, 10'd1, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h0000_FFFF, 10'd16, SN ? 32'h7FFF_8000 : 32'h0, 10'd0, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 32'h4000_0000, 10'h3FB, SN ? 32'h4000_0000 : 32'h0, 10'd0, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b0, 32'h0012_3456, 10'd511, 32'h91A2_B000, 10'd500, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 10'h200, SN ? 32'hFFFF_FFFF : 32'h0, 10'd0, 1'b0, 1'b1};
    req_valid = 2'b11;
    out_ready = 1'b1;
    set_req(0, 1'b0, 10'd100, 32'h0000_1000);
    set_req(1, 1'b1, 10'd5, 32'h8000_0000);
    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_state", {out_valid, busy, out_id, out_mant, out_exp, out_zero, out_uf, out_sign}, 64'd0);
    tick();
    tick();
    chk("rst_hold", {out_valid, busy, req_ready}, 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("alt_gnt%0d", k), 64'(req_ready), k % 2 ? 64'd2 : 64'd1);
      if (k >= 2) chk($sformatf("alt_id%0d", k), {out_valid, out_id}, {1'b1, 1'(k % 2)});
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
    repeat (3) tick();
    chk("alt_idle", 64'(busy), 64'd0);
    for (int k = 0; k < 9; k++) begin
      req_valid = 2'b00;
      set_req(int'(vt[k].id), vt[k].sign, vt[k].exp, vt[k].mant);
      req_valid[vt[k].id] = 1'b1;
      out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", k), 64'(req_ready), vt[k].id ? 64'd2 : 64'd1);
      tick();
      req_valid = 2'b00;
      chk($sformatf("v%0d_lat", k), 64'(out_valid), 64'd0);
      tick();
      chk($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_data", k), {out_id, out_sign, out_mant, out_exp, out_zero, out_uf},
          {vt[k].id, vt[k].sign, vt[k].e_mant, vt[k].e_exp, vt[k].e_zero, vt[k].e_uf});
      tick();
    end
    hs_cnt = 0;
    stream(2, 2'b11, 1'b0);
    snap = {out_valid, out_id, out_mant, out_exp};
    chk("bp_full", 64'(out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      stream(1, 2'b11, 1'b0);
      chk($sformatf("bp_ready%0d", k), 64'(last_ready), 64'd0);
      chk($sformatf("bp_hold%0d", k), {out_valid, out_id, out_mant, out_exp}, snap);
    end
    chk("bp_accepts", 64'(hs_cnt), 64'd2);
    hs_cnt = 0;
    stream(8, 2'b11, 1'b1);
    chk("no_bubble", 64'(hs_cnt), 64'd8);
    stream(4, 2'b00, 1'b1);
    chk("drain_q", 64'(q.size()), 64'd0);
    chk("drain_cnt", 64'(pop_cnt), 64'(push_cnt));
    chk("drain_busy", 64'(busy), 64'd0);
    stream(3, 2'b11, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {out_valid, busy, out_mant, out_exp}, 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    q.delete();
    tick();
    rst_n = 1'b1;
    req_valid = 2'b11;
    out_ready = 1'b1;
    #1;
    chk("rel_gnt", 64'(req_ready), 64'd1);
    tick();
    chk("rel_nostale", 64'(out_valid), 64'd0);
    tick();
    chk("rel_first", {out_valid, out_id}, {1'b1, 1'b0});
    req_valid = 2'b00;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
